rgmii_rx_frame: RTL
===================

# rgmii_rx_frame

Receive-side Ethernet frame engine for the RGMII PHY port, the counterpart of the transmit DDR mux path. It consumes the per-clock demultiplexed RGMII receive byte and control pair and locates preamble and SFD. It strips the FCS, checks CRC-32, length and PHY error, and presents payload bytes to the `top` packet logic as a valid/last stream with a per-frame good flag and saturating frame counters. It runs entirely in the `phy_rx_demux_clk` (125 MHz) domain.

## Interface
- `MAX_LEN`, 1518: maximum frame length in bytes, DA through FCS inclusive.
- `MIN_LEN`, 64: minimum frame length in bytes, DA through FCS inclusive.
- `CNT_W`, 16: width of the status counters.

- `clk`  in  1  `phy_rx_demux_clk`; the block's only clock.
- `reset`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  demuxed byte; `[3:0]` is the rising-edge nibble, `[7:4]` the falling-edge nibble.
- `rx_ctl`  in  2  `[0]` = RX_DV (rising edge); `[1]` = RX_DV xor RX_ER (falling edge).
- `out_data`  out  8  payload byte, DA through the last byte before the FCS.
- `out_valid`  out  1  `out_data` is valid this cycle.
- `out_last`  out  1  qualifies the final payload byte of a frame; only asserted with `out_valid`.
- `out_good`  out  1  meaningful only when `out_last` is high; 1 means CRC ok, no RX_ER, and length within limits.
- `frames_ok`  out  `CNT_W`  saturating count of frames ending with good=1.
- `frames_bad`  out  `CNT_W`  saturating count of bad frames: CRC, RX_ER, length, runt, or bad preamble.

## Operation
- Decode each cycle: dv = `rx_ctl[0]`, er = `rx_ctl[0]^rx_ctl[1]`. When dv=0, er=1 (false carrier or extension) is ignored.
- **IDLE**
  - dv=1 and `rx_data`=0x55 → PREAMBLE.
  - dv=1 with any other byte → DROP, `frames_bad`++.
  - dv=0 → stay.
- **PREAMBLE**
  - 0x55 → stay.
  - 0xD5 (SFD) → DATA; clear length counter, error flag and delay line; set CRC to 0xFFFFFFFF.
  - Any other byte → DROP, `frames_bad`++.
  - dv=0 → IDLE with no count.
- **DATA**, each dv=1 cycle:
  - Byte enters the CRC (reflected, polynomial 0xEDB88320, LSB first) and a 5-byte delay line; length++.
  - er=1 sets the sticky error flag.
  - When the delay line already holds 5 bytes, the oldest byte is emitted with `out_valid`=1 and `out_last`=0.
- **End of frame** (dv falls in DATA):
  - Length ≥5: emit the held 5th-oldest byte with `out_valid`=`out_last`=1.
  - `out_good` = (CRC register == 0xDEBB20E3) && !error flag && `MIN_LEN` ≤ length ≤ `MAX_LEN`.
  - The remaining 4 delay-line bytes (the FCS) are discarded.
  - Increment `frames_ok` or `frames_bad` accordingly; → IDLE.
  - Length <5 (runt): nothing is emitted, `frames_bad`++, → IDLE.
- **Oversize**: when a byte arrives with length already = `MAX_LEN`:
  - That byte is not stored.
  - The oldest delay-line byte is emitted with `out_last`=1, `out_good`=0; `frames_bad`++; → DROP.
- **DROP**: wait for dv=0 → IDLE. No output.
- Counters saturate at all-ones and never wrap.
- Every emitted frame has exactly one `out_last`. Every frame that reaches DATA, plus each bad preamble, increments exactly one counter, once.

## Timing
- **Reset values**: state IDLE, all outputs 0, counters 0, delay line empty. Reset mid-frame discards the frame with no `out_last` and no count. The block resynchronises on the next preamble; if dv is still high, the remainder of the frame lands in IDLE→DROP and counts as one bad frame.
- **Latency**:
  - All outputs are registered.
  - Payload byte k (0 = first byte after SFD) appears on `out_data` one cycle after the cycle that samples byte k+5.
  - The last payload byte appears one cycle after the first dv=0 cycle.
  - Counters update in the same cycle as the corresponding `out_last`.
- **Throughput**: at most one byte per cycle. There is no backpressure; the consumer must accept every `out_valid` cycle.
- **Back-to-back frames**: one dv=0 cycle between frames is sufficient. The end-of-frame output and the new frame's first preamble byte may occur in consecutive cycles.
- **Minimum legal frame**: length 64 gives 60 payload beats; length 5 gives 1 beat.

## Test plan
- **Good frame**: 7×0x55, 0xD5, 60 payload bytes, correct FCS → 60 `out_valid` beats matching the payload; last beat has `out_last`=1, `out_good`=1; `frames_ok`=1.
- **Bad FCS**: same frame with the FCS LSB flipped → 60 beats; `out_good`=0; `frames_bad`=1.
- **RX_ER**: `rx_ctl`=2'b01 (er=1) on payload byte 20 of a good frame → `out_good`=0; `frames_bad`=1.
- **Runt and bad preamble**:
  - SFD plus 3 bytes → no `out_valid`, `frames_bad`=1.
  - dv=1 with first byte 0x12 → no output, `frames_bad`=2 cumulative.
- **Oversize**: `MAX_LEN`+10 bytes → exactly `MAX_LEN`−4 beats; the final beat has `out_last`=1, `out_good`=0; remaining bytes are ignored; `frames_bad`=1.
- **Reset and back-to-back**:
  - Reset asserted at payload byte 30 → no `out_last`, counters 0.
  - Then two good frames separated by one idle cycle → both are delivered intact; `frames_ok`=2.

Source files
------------

// File: rtl/rgmii_rx_frame.sv
// RGMII receive frame engine: finds preamble/SFD, strips FCS, checks CRC/length/RX_ER, counts frames.
// Payload byte k out one cycle after byte k+5 is sampled. There is no backpressure; the consumer takes every beat.
module rgmii_rx_frame #(
  parameter int MAX_LEN = 1518,
  parameter int MIN_LEN = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic [1:0]       rx_ctl,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             out_last,
  output logic             out_good,
  output logic [CNT_W-1:0] frames_ok,
  output logic [CNT_W-1:0] frames_bad
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] MAX_L  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] MIN_L  = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] HOLD_L = LEN_W'(5);
  localparam logic [31:0] POLY    = 32'hEDB88320;
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  state_t           state;
  logic [LEN_W-1:0] len;
  logic [31:0]      crc;
  logic             err;
  logic [4:0][7:0]  dly;

  logic dv;
  logic er;
  logic frame_good;

  assign dv = rx_ctl[0];
  assign er = rx_ctl[0] ^ rx_ctl[1];

  // Running over data+FCS leaves the fixed residue when the FCS matches.
  assign frame_good = (crc == RESIDUE) && !err && (len >= MIN_L) && (len <= MAX_L);

  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ POLY) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      len        <= '0;
      crc        <= '1;
      err        <= 1'b0;
      dly        <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_good   <= 1'b0;
      frames_ok  <= '0;
      frames_bad <= '0;
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_good  <= 1'b0;
      case (state)
        IDLE: begin
          if (dv) begin
            if (rx_data == 8'h55) begin
              state <= PREAMBLE;
            end else begin
              state      <= DROP;
              frames_bad <= sat_inc(frames_bad);
            end
          end
        end
        PREAMBLE: begin
          if (!dv) begin
            state <= IDLE;
          end else if (rx_data == 8'hD5) begin
            state <= DATA;
            len   <= '0;
            crc   <= '1;
            err   <= 1'b0;
            dly   <= '0;
          end else if (rx_data != 8'h55) begin
            state      <= DROP;
            frames_bad <= sat_inc(frames_bad);
          end
        end
        DATA: begin
          if (dv) begin
            if (len == MAX_L) begin
              // Oversize: close the frame on the oldest held byte and discard the rest.
              out_data   <= dly[4];
              out_valid  <= 1'b1;
              out_last   <= 1'b1;
              out_good   <= 1'b0;
              frames_bad <= sat_inc(frames_bad);
              state      <= DROP;
            end else begin
              crc <= crc_next(crc, rx_data);
              dly <= {dly[3:0], rx_data};
              len <= len + 1'b1;
              if (er) begin
                err <= 1'b1;
              end
              if (len >= HOLD_L) begin
                out_data  <= dly[4];
                out_valid <= 1'b1;
              end
            end
          end else begin
            // The four youngest held bytes are the FCS and are dropped here.
            if (len >= HOLD_L) begin
              out_data  <= dly[4];
              out_valid <= 1'b1;
              out_last  <= 1'b1;
              out_good  <= frame_good;
              if (frame_good) begin
                frames_ok <= sat_inc(frames_ok);
              end else begin
                frames_bad <= sat_inc(frames_bad);
              end
            end else begin
              frames_bad <= sat_inc(frames_bad);
            end
            state <= IDLE;
          end
        end
        DROP: begin
          if (!dv) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
